// File: rtl/sig_router_hs.sv
// sig_router_hs
// Registered signal router. One selected input channel is routed to one
// selected output channel through a single holding register. Both sides use
// valid/ready handshakes. The route is programmed through a config handshake.
// A route change passes through DRAIN, where any held beat is delivered on
// the old destination before the new route takes effect.
//
// Handshake rule, for every channel on every interface (cfg, in, out): a
// transfer happens on a rising clk edge where valid && ready are both high.
// A source holds valid and its payload stable until that edge. Readies here
// depend only on registered state and on out_ready, never on the same-side
// valid.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   cfg_valid      route config request
//   cfg_src        input channel to select
//   cfg_dst        output channel to drive
//   cfg_ready      config accepted when cfg_valid && cfg_ready
//   in_data        NIN packed channels, channel i at [i*W +: W]
//   in_valid       per-input valid
//   in_ready       per-input ready (only the routed source can be high)
//   out_data       NOUT packed channels, channel j at [j*W +: W]
//   out_valid      per-output valid (only the routed destination can be high)
//   out_ready      per-output ready
//   route_active   high in state ROUTE
//   beat_count     completed output handshakes, wraps modulo 2^CW
//   state_dbg      current FSM state (0 IDLE, 1 ROUTE, 2 DRAIN)
module sig_router_hs #(
  parameter int NIN  = 4,
  parameter int NOUT = 4,
  parameter int W    = 4,
  parameter int CW   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_valid,
  input  logic [$clog2(NIN)-1:0]     cfg_src,
  input  logic [$clog2(NOUT)-1:0]    cfg_dst,
  output logic                       cfg_ready,
  input  logic [NIN*W-1:0]           in_data,
  input  logic [NIN-1:0]             in_valid,
  output logic [NIN-1:0]             in_ready,
  output logic [NOUT*W-1:0]          out_data,
  output logic [NOUT-1:0]            out_valid,
  input  logic [NOUT-1:0]            out_ready,
  output logic                       route_active,
  output logic [CW-1:0]              beat_count,
  output logic [1:0]                 state_dbg
);

  localparam int SW = $clog2(NIN);
  localparam int DW = $clog2(NOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUTE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  src_q, pend_src;
  logic [DW-1:0]  dst_q, pend_dst;
  logic [W-1:0]   hold_data;
  logic           hold_valid;

  logic           cfg_fire;
  logic           cfg_ok;
  logic           sel_in_valid;
  logic [W-1:0]   sel_in_data;
  logic           sel_out_ready;
  logic           slot_free;
  logic           in_fire;
  logic           out_fire;
  logic           drain_done;

  // Out-of-range selects still complete their handshake but never change
  // the route. Widening to int keeps the compare meaningful when NIN/NOUT
  // are not powers of two.
  assign cfg_fire      = cfg_valid && cfg_ready;
  assign cfg_ok        = (int'(cfg_src) < NIN) && (int'(cfg_dst) < NOUT);

  assign sel_in_valid  = in_valid[src_q];
  assign sel_in_data   = in_data[src_q*W +: W];
  assign sel_out_ready = out_ready[dst_q];

  // The holding register can take a new beat when it is empty or is being
  // emptied in the same cycle; this gives one beat per cycle when streaming.
  assign slot_free  = !hold_valid || sel_out_ready;
  assign in_fire    = (state_q == ST_ROUTE) && sel_in_valid && slot_free;
  assign out_fire   = hold_valid && sel_out_ready;

  // DRAIN may switch the route once nothing remains for the old destination
  // after this edge.
  assign drain_done = (state_q == ST_DRAIN) && (!hold_valid || out_fire);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cfg_fire && cfg_ok) state_d = ST_ROUTE;
      ST_ROUTE: if (cfg_fire && cfg_ok) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_done)         state_d = ST_ROUTE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cfg_ready    = (state_q != ST_DRAIN);
    route_active = (state_q == ST_ROUTE);
    in_ready     = '0;
    out_valid    = '0;
    out_data     = '0;
    if (state_q == ST_ROUTE) begin
      in_ready[src_q] = slot_free;
    end
    // The output side keeps running on dst_q in every state, so a beat held
    // when a reroute arrives still goes to its original destination.
    out_valid[dst_q]        = hold_valid;
    out_data[dst_q*W +: W]  = hold_data;
  end

  assign state_dbg = state_q;

  // Route selection and pending route
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      pend_src <= '0;
      pend_dst <= '0;
    end else begin
      if (state_q == ST_IDLE && cfg_fire && cfg_ok) begin
        src_q <= cfg_src;
        dst_q <= cfg_dst;
      end else if (drain_done) begin
        src_q <= pend_src;
        dst_q <= pend_dst;
      end
      if (state_q == ST_ROUTE && cfg_fire && cfg_ok) begin
        pend_src <= cfg_src;
        pend_dst <= cfg_dst;
      end
    end
  end

  // Holding register and beat counter. A load only happens when the slot is
  // free, so held data never changes while out_valid is high and stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
      beat_count <= '0;
    end else begin
      if (in_fire) begin
        hold_data  <= sel_in_data;
        hold_valid <= 1'b1;
      end else if (out_fire) begin
        hold_valid <= 1'b0;
      end
      if (out_fire) begin
        beat_count <= beat_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sig_router_hs.sv
// Bench for sig_router_hs: a 4x4 instance (W=4, CW=4 so the counter wrap is
// reachable) driven from tables and hand sequences with a scoreboard on the
// output side, plus a 3x3 instance for out-of-range config selects.
module tb_sig_router_hs;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUTE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- 4x4 DUT ----------------
  logic        cfg_valid;
  logic [1:0]  cfg_src, cfg_dst;
  logic        cfg_ready;
  logic [15:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [15:0] out_data;
  logic [3:0]  out_valid, out_ready;
  logic        route_active;
  logic [3:0]  beat_count;
  logic [1:0]  state_dbg;

  sig_router_hs #(.NIN(4), .NOUT(4), .W(4), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_ready(cfg_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .route_active(route_active), .beat_count(beat_count), .state_dbg(state_dbg)
  );

  // ---------------- 3x3 DUT ----------------
  logic        c3_valid;
  logic [1:0]  c3_src, c3_dst;
  logic        c3_ready;
  logic [11:0] i3_data;
  logic [2:0]  i3_valid, i3_ready;
  logic [11:0] o3_data;
  logic [2:0]  o3_valid, o3_ready;
  logic        ra3;
  logic [7:0]  bc3;
  logic [1:0]  sd3;

  sig_router_hs #(.NIN(3), .NOUT(3), .W(4), .CW(8)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(c3_valid), .cfg_src(c3_src), .cfg_dst(c3_dst), .cfg_ready(c3_ready),
    .in_data(i3_data), .in_valid(i3_valid), .in_ready(i3_ready),
    .out_data(o3_data), .out_valid(o3_valid), .out_ready(o3_ready),
    .route_active(ra3), .beat_count(bc3), .state_dbg(sd3)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entries are {2'b00, destination channel, data}.
  logic [7:0] exp_q[$];
  logic [3:0] exp_beats = 4'd0;
  logic [7:0] mon_got, mon_exp;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int j = 0; j < 4; j++) begin
        if (out_valid[j] && out_ready[j]) begin
          mon_got = {2'b00, 2'(j), out_data[j*4 +: 4]};
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: got %h expected no beat", mon_got);
          end else begin
            mon_exp = exp_q.pop_front();
            if (mon_got !== mon_exp) begin
              failures++;
              $display("FAIL sb_beat: got %h expected %h", mon_got, mon_exp);
            end
          end
          exp_beats = exp_beats + 4'd1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks are entered and left one time unit after a rising edge.
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int src, input logic [3:0] d, input int dst);
    bit ok = 0;
    int n = 0;
    in_valid[src] = 1'b1;
    in_data[src*4 +: 4] = d;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      if (in_ready[src]) ok = 1;
    end
    chk("in_handshake", 32'(ok), 32'd1);
    if (ok) exp_q.push_back({2'b00, 2'(dst), d});
    @(posedge clk);
    #1;
    in_valid[src] = 1'b0;
  endtask

  task automatic do_cfg(input logic [1:0] s, input logic [1:0] d);
    bit ok = 0;
    int n = 0;
    cfg_valid = 1'b1;
    cfg_src   = s;
    cfg_dst   = d;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      if (cfg_ready) ok = 1;
    end
    chk("cfg_handshake", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_route();
    bit ok = 0;
    int n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      if (route_active) ok = 1;
    end
    chk("wait_route", 32'(ok), 32'd1);
    sync();
  endtask

  task automatic wait_empty();
    bit ok = 0;
    int n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      n++;
      if (exp_q.size() == 0) ok = 1;
    end
    chk("wait_drained", 32'(ok), 32'd1);
    sync();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  src;
    logic [1:0]  dst;
    logic [3:0]  d;
    logic [3:0]  ov;
    logic [15:0] od;
  } vec_t;

  vec_t tbl[4];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{src: 2'd1, dst: 2'd3, d: 4'b0010, ov: 4'b1000, od: 16'h2000};
    tbl[1] = '{src: 2'd0, dst: 2'd0, d: 4'hA,    ov: 4'b0001, od: 16'h000A};
    tbl[2] = '{src: 2'd2, dst: 2'd1, d: 4'h5,    ov: 4'b0010, od: 16'h0050};
    tbl[3] = '{src: 2'd3, dst: 2'd2, d: 4'hF,    ov: 4'b0100, od: 16'h0F00};

    cfg_valid = 0; cfg_src = 0; cfg_dst = 0;
    in_data = '0; in_valid = '0; out_ready = '0;
    c3_valid = 0; c3_src = 0; c3_dst = 0;
    i3_data = '0; i3_valid = '0; o3_ready = 3'b111;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_route_active", 32'(route_active), 32'd0);
    chk("rst_beat_count", 32'(beat_count), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    #2 rst_n = 1'b1;
    sync();

    // table: route, hold a stalled beat, check the full output vectors
    for (int i = 0; i < 4; i++) begin
      out_ready = '0;
      do_cfg(tbl[i].src, tbl[i].dst);
      wait_route();
      drive_beat(int'(tbl[i].src), tbl[i].d, int'(tbl[i].dst));
      @(negedge clk);
      chk("tbl_out_valid", 32'(out_valid), 32'(tbl[i].ov));
      chk("tbl_out_data", 32'(out_data), 32'(tbl[i].od));
      chk("tbl_in_ready_stalled", 32'(in_ready), 32'd0);
      chk("tbl_route_active", 32'(route_active), 32'd1);
      sync();
      out_ready = 4'hF;
      wait_empty();
    end
    chk("tbl_beat_count", 32'(beat_count), 32'd4);

    // backpressure on src 1 -> dst 3
    out_ready = '0;
    do_cfg(2'd1, 2'd3);
    wait_route();
    drive_beat(1, 4'b0010, 3);
    in_valid[1] = 1'b1;
    in_data[7:4] = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready[1]), 32'd0);
      chk("bp_hold_data", 32'(out_data[15:12]), 32'b0010);
    end
    sync();
    out_ready[3] = 1'b1;
    drive_beat(1, 4'b1101, 3);
    wait_empty();
    chk("bp_beat_count", 32'(beat_count), 32'd6);

    // streaming: 10 back-to-back beats, counter wraps 6+10 -> 0
    out_ready = 4'hF;
    begin
      int t0;
      t0 = cyc;
      for (int k = 0; k < 10; k++) drive_beat(1, 4'($urandom_range(0, 15)), 3);
      chk("stream_cycles", 32'(cyc - t0), 32'd10);
    end
    wait_empty();
    chk("stream_wrap", 32'(beat_count), 32'd0);
    chk("stream_model", 32'(beat_count), 32'(exp_beats));

    // reroute while a beat is stalled on dst 3
    out_ready = '0;
    drive_beat(1, 4'h7, 3);
    do_cfg(2'd3, 2'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("drain_state", 32'(state_dbg), 32'(S_DRAIN));
      chk("drain_cfg_ready", 32'(cfg_ready), 32'd0);
      chk("drain_route_active", 32'(route_active), 32'd0);
      chk("drain_in_ready", 32'(in_ready), 32'd0);
      chk("drain_out_valid", 32'(out_valid), 32'b1000);
    end
    sync();
    out_ready = 4'b1000;
    sync();
    out_ready = '0;
    @(negedge clk);
    chk("reroute_state", 32'(state_dbg), 32'(S_ROUTE));
    chk("reroute_out_valid", 32'(out_valid), 32'd0);
    sync();
    out_ready = 4'b0001;
    drive_beat(3, 4'b0000, 0);
    wait_empty();
    chk("reroute_beat_count", 32'(beat_count), 32'(exp_beats));
    chk("reroute_queue_empty", 32'(exp_q.size()), 32'd0);

    // same route reprogrammed still passes through DRAIN
    do_cfg(2'd3, 2'd0);
    @(negedge clk);
    chk("same_route_drain", 32'(state_dbg), 32'(S_DRAIN));
    @(negedge clk);
    chk("same_route_back", 32'(state_dbg), 32'(S_ROUTE));
    sync();

    // asynchronous reset mid-cycle with a beat held
    out_ready = '0;
    drive_beat(3, 4'h9, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("arst_route_active", 32'(route_active), 32'd0);
    chk("arst_beat_count", 32'(beat_count), 32'd0);
    chk("arst_state", 32'(state_dbg), 32'(S_IDLE));
    exp_q.delete();
    exp_beats = 4'd0;
    @(negedge clk);
    #3 rst_n = 1'b1;
    sync();

    // 3x3 instance: out-of-range configs
    c3_valid = 1'b1; c3_src = 2'd3; c3_dst = 2'd0;
    @(negedge clk);
    chk("d3_cfg_ready", 32'(c3_ready), 32'd1);
    sync();
    c3_valid = 1'b0;
    @(negedge clk);
    chk("d3_oor_idle_state", 32'(sd3), 32'(S_IDLE));
    chk("d3_oor_idle_active", 32'(ra3), 32'd0);
    c3_valid = 1'b1; c3_src = 2'd1; c3_dst = 2'd2;
    sync();
    c3_valid = 1'b0;
    @(negedge clk);
    chk("d3_route_active", 32'(ra3), 32'd1);
    i3_valid[1] = 1'b1;
    i3_data[7:4] = 4'h6;
    #1;
    chk("d3_in_ready", 32'(i3_ready), 32'b010);
    sync();
    i3_valid = '0;
    @(negedge clk);
    chk("d3_out_valid", 32'(o3_valid), 32'b100);
    chk("d3_out_data", 32'(o3_data), 32'h600);
    c3_valid = 1'b1; c3_src = 2'd0; c3_dst = 2'd3;
    sync();
    c3_valid = 1'b0;
    @(negedge clk);
    chk("d3_oor_route_state", 32'(sd3), 32'(S_ROUTE));
    chk("d3_oor_route_active", 32'(ra3), 32'd1);
    i3_valid[1] = 1'b1;
    i3_data[7:4] = 4'h9;
    #1;
    chk("d3_in_ready2", 32'(i3_ready), 32'b010);
    sync();
    i3_valid = '0;
    @(negedge clk);
    chk("d3_out_valid2", 32'(o3_valid), 32'b100);
    chk("d3_out_data2", 32'(o3_data), 32'h900);
    sync();
    chk("d3_beat_count", 32'(bc3), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
